alu_32: RTL and testbench

- 32-bit registered ALU for the single-cycle processor datapath.
- Computes one of eight arithmetic/logic/shift operations on two 32-bit operands, selected by a 3-bit control code.
- Result, carry flag and zero flag are captured on the rising clock edge and held until the next edge.
- Feeds the register-file write-back path and the branch-decision logic (via oZero).

---
 rtl/alu_32.sv | 114 +++++++++++
 tb/tb_alu_32.sv | 132 +++++++++++++
 2 files changed

// File: rtl/alu_32.sv
// Registered 32-bit ALU: eight arithmetic/logic/shift operations selected by ctrl,
// with result, carry/borrow and zero flag captured together on each rising clock edge.
module alu_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [2:0]       ctrl,
    output logic [WIDTH-1:0] out,
    output logic             oCarry,
    output logic             oZero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    // 33-bit sum; the top bit is the carry out.
    function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        add_ext = {1'b0, a} + {1'b0, b};
    endfunction

    // 33-bit difference; the top bit is set exactly when a < b unsigned (borrow).
    function automatic logic [WIDTH:0] sub_ext(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        sub_ext = {1'b0, a} - {1'b0, b};
    endfunction

    // Shifting a zero-extended operand leaves the last bit shifted out in the top
    // position, and leaves it zero when the shift amount is zero.
    function automatic logic [WIDTH:0] sll_ext(input logic [WIDTH-1:0] a,
                                               input logic [SHW-1:0]   sh);
        sll_ext = {1'b0, a} << sh;
    endfunction

    function automatic logic slt_signed(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
        slt_signed = ($signed(a) < $signed(b)) ? 1'b1 : 1'b0;
    endfunction

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH:0]   sll_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             zero_s;

    logic [WIDTH-1:0] out_r;
    logic             carry_r;
    logic             zero_r;

    assign add_s = add_ext(iA, iB);
    assign sub_s = sub_ext(iA, iB);
    assign sll_s = sll_ext(iA, iB[SHW-1:0]);

    // Operation select: next-state result and carry/borrow.
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        case (ctrl)
            OP_ADD: begin
                res_s   = add_s[WIDTH-1:0];
                carry_s = add_s[WIDTH];
            end
            OP_SUB: begin
                res_s   = sub_s[WIDTH-1:0];
                carry_s = sub_s[WIDTH];
            end
            OP_AND: res_s = iA & iB;
            OP_OR:  res_s = iA | iB;
            OP_XOR: res_s = iA ^ iB;
            OP_NOR: res_s = ~(iA | iB);
            OP_SLT: res_s = {{(WIDTH-1){1'b0}}, slt_signed(iA, iB)};
            OP_SLL: begin
                res_s   = sll_s[WIDTH-1:0];
                carry_s = sll_s[WIDTH];
            end
            default: begin
                res_s   = {WIDTH{1'b0}};
                carry_s = 1'b0;
            end
        endcase
    end

    assign zero_s = (res_s == {WIDTH{1'b0}}) ? 1'b1 : 1'b0;

    // Output registers; reset presents a zero result, so the zero flag reads 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            zero_r  <= 1'b1;
        end else begin
            out_r   <= res_s;
            carry_r <= carry_s;
            zero_r  <= zero_s;
        end
    end

    assign out    = out_r;
    assign oCarry = carry_r;
    assign oZero  = zero_r;

endmodule

// File: tb/tb_alu_32.sv
// Directed self-checking bench for alu_32: reset, every opcode, boundary cases,
// one-cycle latency and asynchronous mid-stream reset.
module tb_alu_32;

    logic        clk;
    logic        rst;
    logic [31:0] iA;
    logic [31:0] iB;
    logic [2:0]  ctrl;
    logic [31:0] out;
    logic        oCarry;
    logic        oZero;

    int n_checks;
    int n_fail;

    alu_32 dut (
        .clk    (clk),
        .rst    (rst),
        .iA     (iA),
        .iB     (iB),
        .ctrl   (ctrl),
        .out    (out),
        .oCarry (oCarry),
        .oZero  (oZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_out,
                             input logic e_c, input logic e_z);
        check_val({tag, ".out"},   out,             e_out);
        check_val({tag, ".carry"}, {31'd0, oCarry}, {31'd0, e_c});
        check_val({tag, ".zero"},  {31'd0, oZero},  {31'd0, e_z});
    endtask

    // Drive on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c, input logic [31:0] e_out,
                          input logic e_c, input logic e_z);
        @(negedge clk);
        iA   = a;
        iB   = b;
        ctrl = c;
        @(posedge clk);
        #1;
        check_all(tag, e_out, e_c, e_z);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        iA   = 32'hDEAD_BEEF;
        iB   = 32'h1234_5678;
        ctrl = 3'b000;

        // Reset with no clock edge yet (first rising edge at t=5)
        #1 rst = 1'b1;
        #2;
        check_all("reset", 32'h0000_0000, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_ovf",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("add_ident", 32'hFFFF_FFFF, 32'h0000_0000, 3'b000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 32'h0000_0000, 1'b1, 1'b1);
        run_op("add_plain", 32'h0000_1000, 32'h0000_0234, 3'b000, 32'h0000_1234, 1'b0, 1'b0);

        run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 3'b001, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("sub_equal",  32'h0000_1234, 32'h0000_1234, 3'b001, 32'h0000_0000, 1'b0, 1'b1);
        run_op("sub_plain",  32'h0000_0007, 32'h0000_0005, 3'b001, 32'h0000_0002, 1'b0, 1'b0);

        run_op("and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 32'h00F0_00F0, 1'b0, 1'b0);
        run_op("or",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 32'hFFF0_FFF0, 1'b0, 1'b0);
        run_op("xor", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 32'hFF00_FF00, 1'b0, 1'b0);
        run_op("nor", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b101, 32'h000F_000F, 1'b0, 1'b0);
        run_op("xor_self", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b100, 32'h0000_0000, 1'b0, 1'b1);

        run_op("slt_neg",  32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 32'h0000_0001, 1'b0, 1'b0);
        run_op("slt_min",  32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 32'h0000_0001, 1'b0, 1'b0);
        run_op("slt_rev",  32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 32'h0000_0000, 1'b0, 1'b1);

        run_op("sll_1",    32'h8000_0001, 32'h0000_0021, 3'b111, 32'h0000_0002, 1'b1, 1'b0);
        run_op("sll_31",   32'h0000_0003, 32'h0000_001F, 3'b111, 32'h8000_0000, 1'b1, 1'b0);
        run_op("sll_0",    32'h1234_5678, 32'h0000_0020, 3'b111, 32'h1234_5678, 1'b0, 1'b0);
        run_op("sll_4",    32'hF000_000F, 32'h0000_0004, 3'b111, 32'h0000_00F0, 1'b1, 1'b0);
        run_op("sll_nocy", 32'h0000_0001, 32'h0000_0004, 3'b111, 32'h0000_0010, 1'b0, 1'b0);

        // Latency: mid-cycle input change must not reach the outputs before the edge
        run_op("lat_base", 32'h0000_0010, 32'h0000_0020, 3'b000, 32'h0000_0030, 1'b0, 1'b0);
        @(negedge clk);
        iA   = 32'hFFFF_FFFF;
        iB   = 32'h0000_0001;
        ctrl = 3'b000;
        #2;
        check_all("lat_hold", 32'h0000_0030, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("lat_load", 32'h0000_0000, 1'b1, 1'b1);

        // Asynchronous reset between edges, then first edge loads current inputs
        run_op("pre_rst", 32'h0000_0005, 32'h0000_0007, 3'b001, 32'hFFFF_FFFE, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("rst_mid", 32'h0000_0000, 1'b0, 1'b1);
        @(negedge clk);
        iA   = 32'hFFFF_FFFF;
        iB   = 32'hFFFF_FFFF;
        ctrl = 3'b000;
        rst  = 1'b0;
        #1;
        check_all("rst_rel", 32'h0000_0000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_all("rst_first", 32'hFFFF_FFFE, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
